piece_motion_ctrl: RTL and testbench

PIECE_MOTION_CTRL -- requirements
Module: piece_motion_ctrl

---
 rtl/piece_pkg.sv | 77 +++++++
 rtl/piece_cells.sv | 38 +++
 rtl/piece_motion_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_piece_motion_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_pkg.sv
// Shared types, field geometry and tetromino offset table for the piece motion controller.
// Optional feature macro: ROTATE_EN (rotation offsets are only compiled when it is defined).
package piece_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_WAIT,
    ST_CHECK,
    ST_COMMIT,
    ST_LOCK
  } state_t;

  typedef enum logic [1:0] {
    KIND_SPAWN,
    KIND_SHIFT,
    KIND_GRAVITY
  } kind_t;

  localparam int         NUM_COLS  = 10;
  localparam int         NUM_ROWS  = 20;
  localparam logic [3:0] SPAWN_COL = 4'd4;
  localparam logic [4:0] SPAWN_ROW = 5'd0;

  // Four cells packed as {dx[1:0], dy[1:0]}, cell 1 in the top nibble.
`ifdef ROTATE_EN
  function automatic logic [15:0] cell_offsets(input logic [2:0] ptype, input logic [1:0] rot);
    logic [15:0] offs;
    case (ptype)
      3'd1: offs = 16'h0415;
      3'd2: begin
        case (rot)
          2'd0:    offs = 16'h0485;
          2'd1:    offs = 16'h4561;
          2'd2:    offs = 16'h4159;
          default: offs = 16'h0125;
        endcase
      end
      3'd3: offs = rot[0] ? 16'h0156 : 16'h4815;
      3'd4: offs = rot[0] ? 16'h4512 : 16'h0459;
      3'd5: begin
        case (rot)
          2'd0:    offs = 16'h0159;
          2'd1:    offs = 16'h0412;
          2'd2:    offs = 16'h0489;
          default: offs = 16'h4526;
        endcase
      end
      3'd6: begin
        case (rot)
          2'd0:    offs = 16'h8159;
          2'd1:    offs = 16'h0126;
          2'd2:    offs = 16'h0481;
          default: offs = 16'h0456;
        endcase
      end
      default: offs = rot[0] ? 16'h4567 : 16'h048C;
    endcase
    return offs;
  endfunction
`else
  function automatic logic [15:0] cell_offsets(input logic [2:0] ptype);
    logic [15:0] offs;
    case (ptype)
      3'd1:    offs = 16'h0415;
      3'd2:    offs = 16'h0485;
      3'd3:    offs = 16'h4815;
      3'd4:    offs = 16'h0459;
      3'd5:    offs = 16'h0159;
      3'd6:    offs = 16'h8159;
      default: offs = 16'h048C;
    endcase
    return offs;
  endfunction
`endif

endpackage

// File: rtl/piece_cells.sv
// Maps an anchor, piece type and rotation to four (col,row) cells plus an in-field flag.
// Optional feature macro: ROTATE_EN.
module piece_cells
  import piece_pkg::*;
(
  input  logic [3:0]      anchor_col,
  input  logic [4:0]      anchor_row,
  input  logic [2:0]      ptype,
  input  logic [1:0]      rot,
  output logic [3:0][4:0] cell_col,
  output logic [3:0][5:0] cell_row,
  output logic            in_field
);

  logic [15:0] offs;
  logic [3:0]  cell_ok;

`ifdef ROTATE_EN
  assign offs = cell_offsets(ptype, rot);
`else
  logic unused_rot;
  assign unused_rot = ^rot;
  assign offs       = cell_offsets(ptype);
`endif

  // A left move from column 0 wraps the anchor to 15, which lands here as out of field.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      assign cell_col[gi] = {1'b0, anchor_col} + {3'b000, offs[15-4*gi -: 2]};
      assign cell_row[gi] = {1'b0, anchor_row} + {4'b0000, offs[13-4*gi -: 2]};
      assign cell_ok[gi]  = (cell_col[gi] < 5'(NUM_COLS)) && (cell_row[gi] < 6'(NUM_ROWS));
    end
  endgenerate

  assign in_field = &cell_ok;

endmodule

// File: rtl/piece_motion_ctrl.sv
// Falling-piece controller: spawn, lateral/rotate/gravity moves via board collision queries, lock.
// Optional feature macro: ROTATE_EN enables rotation moves.
module piece_motion_ctrl
  import piece_pkg::*;
#(
  parameter int FALL_FRAMES = 30,
  parameter int FIELD_X0    = 240,
  parameter int FIELD_Y0    = 80,
  parameter int CELL        = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       rotate,
  input  logic       drop_fast,
  input  logic [2:0] piece_type,
  output logic       check_req,
  output logic [3:0] cand_col,
  output logic [4:0] cand_row,
  output logic [1:0] cand_rot,
  input  logic       check_ack,
  input  logic       check_blocked,
  output logic [9:0] CBlock1X,
  output logic [9:0] CBlock2X,
  output logic [9:0] CBlock3X,
  output logic [9:0] CBlock4X,
  output logic [9:0] CBlock1Y,
  output logic [9:0] CBlock2Y,
  output logic [9:0] CBlock3Y,
  output logic [9:0] CBlock4Y,
  output logic       landed,
  output logic       game_over
);

  localparam int CW = $clog2(FALL_FRAMES + 1);
`ifdef ROTATE_EN
  localparam logic [15:0] RST_OFFS = cell_offsets(3'd0, 2'd0);
`else
  localparam logic [15:0] RST_OFFS = cell_offsets(3'd0);
`endif

  function automatic logic [9:0] pix(input int base, input logic [5:0] idx);
    return 10'(base + CELL / 2) + 10'(idx) * 10'(CELL);
  endfunction

  state_t          state_reg, state_next;
  kind_t           kind_reg, kind_next;
  logic [CW-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [3:0]      anchor_col_reg, anchor_col_next, cand_col_reg, cand_col_next;
  logic [4:0]      anchor_row_reg, anchor_row_next, cand_row_reg, cand_row_next;
  logic [1:0]      anchor_rot_reg, anchor_rot_next, cand_rot_reg, cand_rot_next;
  logic [2:0]      type_reg, type_next;
  logic            landed_reg, landed_next, game_over_reg, game_over_next;
  logic            commit_d_reg, commit_d_next;
  logic            gravity, rot_sel, cand_in_field, com_in_field_unused;
  logic [3:0][4:0] cand_cells_col, com_col;
  logic [3:0][5:0] cand_cells_row, com_row;
  logic [9:0]      pix_x [4], pix_y [4], rst_x [4], rst_y [4];
  logic [9:0]      cblk_x_reg [4], cblk_y_reg [4];

`ifdef ROTATE_EN
  assign rot_sel  = rotate;
  assign cand_rot = cand_rot_reg;
`else
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign rot_sel       = 1'b0;
  assign cand_rot      = 2'd0;
`endif

  piece_cells u_cand_cells (
    .anchor_col(cand_col_reg), .anchor_row(cand_row_reg), .ptype(type_reg), .rot(cand_rot_reg),
    .cell_col(cand_cells_col), .cell_row(cand_cells_row), .in_field(cand_in_field)
  );

  piece_cells u_com_cells (
    .anchor_col(anchor_col_reg), .anchor_row(anchor_row_reg), .ptype(type_reg), .rot(anchor_rot_reg),
    .cell_col(com_col), .cell_row(com_row), .in_field(com_in_field_unused)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pix
      assign pix_x[gi] = pix(FIELD_X0, {1'b0, com_col[gi]});
      assign pix_y[gi] = pix(FIELD_Y0, com_row[gi]);
      assign rst_x[gi] = pix(FIELD_X0, 6'(SPAWN_COL) + 6'(RST_OFFS[15-4*gi -: 2]));
      assign rst_y[gi] = pix(FIELD_Y0, 6'(SPAWN_ROW) + 6'(RST_OFFS[13-4*gi -: 2]));
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      kind_reg       <= KIND_SPAWN;
      frame_cnt_reg  <= '0;
      anchor_col_reg <= SPAWN_COL;
      anchor_row_reg <= SPAWN_ROW;
      anchor_rot_reg <= 2'd0;
      cand_col_reg   <= SPAWN_COL;
      cand_row_reg   <= SPAWN_ROW;
      cand_rot_reg   <= 2'd0;
      type_reg       <= 3'd0;
      landed_reg     <= 1'b0;
      game_over_reg  <= 1'b0;
      commit_d_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      kind_reg       <= kind_next;
      frame_cnt_reg  <= frame_cnt_next;
      anchor_col_reg <= anchor_col_next;
      anchor_row_reg <= anchor_row_next;
      anchor_rot_reg <= anchor_rot_next;
      cand_col_reg   <= cand_col_next;
      cand_row_reg   <= cand_row_next;
      cand_rot_reg   <= cand_rot_next;
      type_reg       <= type_next;
      landed_reg     <= landed_next;
      game_over_reg  <= game_over_next;
      commit_d_reg   <= commit_d_next;
    end
  end

  // Pixel centres follow the anchor one Clk after it is committed.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        cblk_x_reg[i] <= rst_x[i];
        cblk_y_reg[i] <= rst_y[i];
      end
    end else if (commit_d_reg) begin
      for (int i = 0; i < 4; i++) begin
        cblk_x_reg[i] <= pix_x[i];
        cblk_y_reg[i] <= pix_y[i];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    kind_next       = kind_reg;
    frame_cnt_next  = frame_cnt_reg;
    anchor_col_next = anchor_col_reg;
    anchor_row_next = anchor_row_reg;
    anchor_rot_next = anchor_rot_reg;
    cand_col_next   = cand_col_reg;
    cand_row_next   = cand_row_reg;
    cand_rot_next   = cand_rot_reg;
    type_next       = type_reg;
    landed_next     = 1'b0;
    game_over_next  = game_over_reg;
    commit_d_next   = 1'b0;
    gravity         = drop_fast || (frame_cnt_reg == CW'(FALL_FRAMES - 1));
    case (state_reg)
      ST_IDLE: begin
        if (frame_tick && start) begin
          game_over_next = 1'b0;
          state_next     = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        type_next      = piece_type;
        cand_col_next  = SPAWN_COL;
        cand_row_next  = SPAWN_ROW;
        cand_rot_next  = 2'd0;
        kind_next      = KIND_SPAWN;
        frame_cnt_next = '0;
        state_next     = ST_CHECK;
      end
      ST_WAIT: begin
        if (frame_tick) begin
          cand_col_next = anchor_col_reg;
          cand_row_next = anchor_row_reg;
          cand_rot_next = anchor_rot_reg;
          kind_next     = KIND_SHIFT;
          state_next    = ST_CHECK;
          if (rot_sel) cand_rot_next = anchor_rot_reg + 2'd1;
          else if (move_left) cand_col_next = anchor_col_reg - 4'd1;
          else if (move_right) cand_col_next = anchor_col_reg + 4'd1;
          else if (gravity) begin
            cand_row_next = anchor_row_reg + 5'd1;
            kind_next     = KIND_GRAVITY;
          end else begin
            state_next     = ST_WAIT;
            frame_cnt_next = frame_cnt_reg + CW'(1);
          end
        end
      end
      ST_CHECK: begin
        // Out-of-field candidates resolve at once, as if the board had answered blocked.
        if (!cand_in_field || check_ack) begin
          if (cand_in_field && !check_blocked) state_next = ST_COMMIT;
          else begin
            case (kind_reg)
              KIND_SPAWN: begin
                game_over_next = 1'b1;
                state_next     = ST_IDLE;
              end
              KIND_GRAVITY: begin
                landed_next = 1'b1;
                state_next  = ST_LOCK;
              end
              default: state_next = ST_WAIT;
            endcase
          end
        end
      end
      ST_COMMIT: begin
        anchor_col_next = cand_col_reg;
        anchor_row_next = cand_row_reg;
        anchor_rot_next = cand_rot_reg;
        if (kind_reg == KIND_GRAVITY) frame_cnt_next = '0;
        commit_d_next = 1'b1;
        state_next    = ST_WAIT;
      end
      ST_LOCK: begin
        if (frame_tick && !landed_reg) state_next = ST_SPAWN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign check_req = (state_reg == ST_CHECK) && cand_in_field;
  assign cand_col  = cand_col_reg;
  assign cand_row  = cand_row_reg;
  assign landed    = landed_reg;
  assign game_over = game_over_reg;
  assign CBlock1X  = cblk_x_reg[0];
  assign CBlock2X  = cblk_x_reg[1];
  assign CBlock3X  = cblk_x_reg[2];
  assign CBlock4X  = cblk_x_reg[3];
  assign CBlock1Y  = cblk_y_reg[0];
  assign CBlock2Y  = cblk_y_reg[1];
  assign CBlock3Y  = cblk_y_reg[2];
  assign CBlock4Y  = cblk_y_reg[3];

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Scenario bench for piece_motion_ctrl: expected queries are queued when a frame_tick is driven
// and popped when check_req appears; pixel centres are checked against hand-derived values.
module tb_piece_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, start, move_left, move_right, rotate, drop_fast;
  logic [2:0] piece_type;
  logic       check_ack, check_blocked;
  logic       check_req, landed, game_over;
  logic [3:0] cand_col;
  logic [4:0] cand_row;
  logic [1:0] cand_rot;
  logic [9:0] CBlock1X, CBlock2X, CBlock3X, CBlock4X, CBlock1Y, CBlock2Y, CBlock3Y, CBlock4Y;

  typedef struct packed {
    logic [3:0] col;
    logic [4:0] row;
    logic [1:0] rot;
  } query_t;

  query_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  always #5 Clk = ~Clk;

  piece_motion_ctrl #(.FALL_FRAMES(30), .FIELD_X0(240), .FIELD_Y0(80), .CELL(16)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .move_left(move_left), .move_right(move_right), .rotate(rotate), .drop_fast(drop_fast),
    .piece_type(piece_type), .check_req(check_req), .cand_col(cand_col), .cand_row(cand_row),
    .cand_rot(cand_rot), .check_ack(check_ack), .check_blocked(check_blocked),
    .CBlock1X(CBlock1X), .CBlock2X(CBlock2X), .CBlock3X(CBlock3X), .CBlock4X(CBlock4X),
    .CBlock1Y(CBlock1Y), .CBlock2Y(CBlock2Y), .CBlock3Y(CBlock3Y), .CBlock4Y(CBlock4Y),
    .landed(landed), .game_over(game_over)
  );

  task automatic tick();
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_req(output bit seen, output query_t got, output query_t want);
    seen = 1'b0;
    want = '0;
    for (int i = 0; i < 20; i++) begin
      if (check_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    got = {cand_col, cand_row, cand_rot};
    if (exp_q.size() > 0) want = exp_q.pop_front();
    $display("query seen=%0d col=%0d row=%0d rot=%0d", seen, got.col, got.row, got.rot);
  endtask

  task automatic respond(input logic blk);
    check_ack     = 1'b1;
    check_blocked = blk;
    @(negedge Clk);
    check_ack     = 1'b0;
    check_blocked = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_tick = 0; start = 0; move_left = 0; move_right = 0; rotate = 0;
    drop_fast = 0; piece_type = 3'd0; check_ack = 0; check_blocked = 0;
    repeat (2) @(negedge Clk);
    checks++; if (check_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", check_req); end
    checks++; if (landed !== 1'b0) begin failures++; $display("FAIL reset_landed got=%b want=0", landed); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%b want=0", game_over); end
    checks++; if (cand_col !== 4'd4 || cand_row !== 5'd0) begin failures++; $display("FAIL reset_cand got=%0d,%0d want=4,0", cand_col, cand_row); end
    checks++; if (CBlock1X !== 10'd312 || CBlock4X !== 10'd360) begin failures++; $display("FAIL reset_x got=%0d,%0d want=312,360", CBlock1X, CBlock4X); end
    checks++; if (CBlock1Y !== 10'd88 || CBlock4Y !== 10'd88) begin failures++; $display("FAIL reset_y got=%0d,%0d want=88,88", CBlock1Y, CBlock4Y); end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_spawn_gravity();
    bit seen; query_t got, want; int early;
    piece_type = 3'd0; start = 1'b1;
    exp_q.push_back({4'd4, 5'd0, 2'd0});
    tick(); start = 1'b0;
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL spawn_query got=%h want=%h seen=%0d", got, want, seen); end
    respond(1'b0); settle();
    checks++; if (CBlock1Y !== 10'd88 || CBlock1X !== 10'd312) begin failures++; $display("FAIL spawn_pix got=%0d,%0d want=312,88", CBlock1X, CBlock1Y); end
    early = 0;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (check_req) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL gravity_early got=%0d want=0", early); end
    exp_q.push_back({4'd4, 5'd1, 2'd0});
    tick();
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL gravity_query got=%h want=%h seen=%0d", got, want, seen); end
    checks++; if (CBlock1Y !== 10'd88) begin failures++; $display("FAIL hold_during_check got=%0d want=88", CBlock1Y); end
    respond(1'b0); settle();
    checks++; if (CBlock1Y !== 10'd104) begin failures++; $display("FAIL gravity_row1 got=%0d want=104", CBlock1Y); end
  endtask

  task automatic test_left_wall();
    bit seen; query_t got, want; int n;
    move_left = 1'b1;
    for (int c = 3; c >= 0; c--) begin
      exp_q.push_back({4'(c), 5'd1, 2'd0});
      tick();
      wait_req(seen, got, want);
      checks++; if (!seen || got !== want) begin failures++; $display("FAIL left_query got=%h want=%h seen=%0d", got, want, seen); end
      respond(1'b0); settle();
    end
    tick();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (check_req) n++;
      @(negedge Clk);
    end
    move_left = 1'b0;
    checks++; if (n !== 0) begin failures++; $display("FAIL wall_no_req got=%0d want=0", n); end
    checks++; if (CBlock1X !== 10'd248 || CBlock1Y !== 10'd104) begin failures++; $display("FAIL wall_anchor got=%0d,%0d want=248,104", CBlock1X, CBlock1Y); end
  endtask

  task automatic test_rotate_priority();
    bit seen; query_t got, want;
    rotate = 1'b1; move_right = 1'b1;
`ifdef ROTATE_EN
    exp_q.push_back({4'd0, 5'd1, 2'd1});
`else
    exp_q.push_back({4'd1, 5'd1, 2'd0});
`endif
    tick(); rotate = 1'b0; move_right = 1'b0;
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL priority_query got=%h want=%h seen=%0d", got, want, seen); end
    respond(1'b1); settle();
    checks++; if (CBlock1X !== 10'd248 || CBlock1Y !== 10'd104) begin failures++; $display("FAIL blocked_holds got=%0d,%0d want=248,104", CBlock1X, CBlock1Y); end
  endtask

  task automatic test_landing();
    bit seen; query_t got, want; int n;
    drop_fast = 1'b1;
    exp_q.push_back({4'd0, 5'd2, 2'd0});
    tick(); drop_fast = 1'b0;
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL drop_query got=%h want=%h seen=%0d", got, want, seen); end
    check_ack = 1'b1; check_blocked = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (i == 0) begin check_ack = 1'b0; check_blocked = 1'b0; end
      if (landed) n++;
    end
    checks++; if (n !== 1) begin failures++; $display("FAIL landed_pulse got=%0d want=1", n); end
    piece_type = 3'd1;
    exp_q.push_back({4'd4, 5'd0, 2'd0});
    tick();
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL respawn_query got=%h want=%h seen=%0d", got, want, seen); end
    respond(1'b0); settle();
    checks++; if (CBlock2X !== 10'd328 || CBlock3X !== 10'd312 || CBlock3Y !== 10'd104) begin
      failures++; $display("FAIL o_piece_pix got=%0d,%0d,%0d want=328,312,104", CBlock2X, CBlock3X, CBlock3Y);
    end
  endtask

  task automatic test_game_over();
    bit seen; query_t got, want; int n;
    drop_fast = 1'b1;
    exp_q.push_back({4'd4, 5'd1, 2'd0});
    tick(); drop_fast = 1'b0;
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL lock_query got=%h want=%h seen=%0d", got, want, seen); end
    respond(1'b1); settle();
    piece_type = 3'd2;
    exp_q.push_back({4'd4, 5'd0, 2'd0});
    tick();
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL blocked_spawn_query got=%h want=%h seen=%0d", got, want, seen); end
    respond(1'b1); settle();
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL game_over_set got=%b want=1", game_over); end
    checks++; if (CBlock3X !== 10'd312 || CBlock3Y !== 10'd104) begin failures++; $display("FAIL last_piece_held got=%0d,%0d want=312,104", CBlock3X, CBlock3Y); end
    tick();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (check_req) n++;
      @(negedge Clk);
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL idle_ignores_tick got=%0d want=0", n); end
    start = 1'b1;
    exp_q.push_back({4'd4, 5'd0, 2'd0});
    tick(); start = 1'b0;
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL game_over_cleared got=%b want=0", game_over); end
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL restart_query got=%h want=%h seen=%0d", got, want, seen); end
    respond(1'b0); settle();
    checks++; if (CBlock3X !== 10'd344 || CBlock4Y !== 10'd104) begin failures++; $display("FAIL t_piece_pix got=%0d,%0d want=344,104", CBlock3X, CBlock4Y); end
  endtask

  task automatic test_reset_during_check();
    bit seen; query_t got, want; int n;
    move_right = 1'b1;
    exp_q.push_back({4'd5, 5'd0, 2'd0});
    tick(); move_right = 1'b0;
    wait_req(seen, got, want);
    checks++; if (!seen || got !== want) begin failures++; $display("FAIL right_query got=%h want=%h seen=%0d", got, want, seen); end
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    respond(1'b0); settle();
    checks++; if (check_req !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL abandon_flags got=%b,%b want=0,0", check_req, game_over); end
    checks++; if (cand_col !== 4'd4) begin failures++; $display("FAIL abandon_cand got=%0d want=4", cand_col); end
    checks++; if (CBlock1X !== 10'd312 || CBlock4X !== 10'd360 || CBlock4Y !== 10'd88) begin
      failures++; $display("FAIL abandon_anchor got=%0d,%0d,%0d want=312,360,88", CBlock1X, CBlock4X, CBlock4Y);
    end
    tick();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (check_req) n++;
      @(negedge Clk);
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL post_reset_idle got=%0d want=0", n); end
  endtask

  initial begin
    test_reset();
    test_spawn_gravity();
    test_left_wall();
    test_rotate_priority();
    test_landing();
    test_game_over();
    test_reset_during_check();
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
